alu_arbiter: RTL and testbench

Shares one instance of the team's 8-bit combinational alu between two requesters, which each present an operand/opcode bundle over a valid/ready handshake. A 3-state FSM sequences the work: grant, latch the operands, drive the ALU, register the result, then hold it on a single response channel with backpressure. Arbitration is round-robin, and the response is tagged with the requester id. The block sits between the two front-end masters and the ALU datapath.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu.sv | 27 ++
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU and its two-requester arbiter.
package alu_pkg;

    localparam int W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU: add/sub/and/or with optional result inversion.
module alu
    import alu_pkg::*;
(
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [1:0]   aluop,
    input  logic         neg,
    output logic [W-1:0] O
);

    logic [W-1:0] res;

    // Select the operation; add and sub wrap modulo 2^W, neg is a bitwise NOT.
    always_comb begin
        res = A + B;
        case (aluop)
            OP_ADD: res = A + B;
            OP_SUB: res = A - B;
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            default: res = A + B;
        endcase
        O = neg ? ~res : res;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// IDLE grants and latches operands, EXEC captures the ALU output,
// RESP holds the tagged result until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req0_neg,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [1:0]       req1_op,
    input  logic             req1_neg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    arb_state_t       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic             gnt_any;
    logic             gnt_id;
    logic [W-1:0]     alu_o;

    // The ALU only ever sees the latched operands, so requester inputs
    // are free to change once accepted.
    alu u_alu (
        .A     (a_q),
        .B     (b_q),
        .aluop (op_q),
        .neg   (neg_q),
        .O     (alu_o)
    );

    // Grant selection: a lone requester wins; on contention the one that
    // did not win last time goes.
    always_comb begin
        gnt_any    = req0_valid | req1_valid;
        gnt_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = (state_q == IDLE) && gnt_any && !gnt_id;
        req1_ready = (state_q == IDLE) && gnt_any &&  gnt_id;
    end

    // Next-state and datapath update for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        neg_d        = neg_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    a_d          = gnt_id ? req1_a   : req0_a;
                    b_d          = gnt_id ? req1_b   : req0_b;
                    op_d         = gnt_id ? req1_op  : req0_op;
                    neg_d        = gnt_id ? req1_neg : req0_neg;
                    id_d         = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_o;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_id_q) cnt1_d = cnt1_q + CNT_W'(1);
                    else          cnt0_d = cnt0_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any in-flight result without counting it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            neg_q        <= 1'b0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            neg_q        <= neg_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt0 = cnt0_q;
    assign done_cnt1 = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a second instance with CNT_W=2 shares
// all inputs so counter wrap can be observed.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0, req0_neg = 0, req1_neg = 0;
    logic [7:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [1:0]  req0_op = 0, req1_op = 0;
    logic        rsp_ready = 0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [7:0]  rsp_data;
    logic [15:0] done_cnt0, done_cnt1;
    logic        w_req0_ready, w_req1_ready, w_rsp_valid, w_rsp_id, w_busy;
    logic [7:0]  w_rsp_data;
    logic [1:0]  w_done_cnt0, w_done_cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_neg(req0_neg),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_neg(req1_neg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    alu_arbiter #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_neg(req0_neg),
        .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_neg(req1_neg),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(w_rsp_data), .rsp_id(w_rsp_id),
        .busy(w_busy), .done_cnt0(w_done_cnt0), .done_cnt1(w_done_cnt1)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Drive one request, wait (bounded) for acceptance and response, then
    // take the response. lat counts negedges from the accept cycle; -1 on timeout.
    task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic n,
                         output logic [7:0] d, output logic rid, output int lat);
        bit acc;
        @(negedge clk);
        if (id == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; req0_neg = n; end
        else         begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; req1_neg = n; end
        #1;
        acc = 0;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin acc = 1; break; end
            @(negedge clk); #1;
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        if (acc) begin
            for (int i = 1; i < 10; i++) begin
                if (rsp_valid) begin lat = i; break; end
                @(negedge clk);
            end
        end
        d = rsp_data; rid = rsp_id;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end n_assert++;
        if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end n_assert++;
        if (rsp_id !== 1'b0)    begin n_fail++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end n_assert++;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end n_assert++;
        if (done_cnt0 !== 16'd0 || done_cnt1 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", done_cnt0, done_cnt1); end n_assert++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end n_assert++;
        rst_n = 1;
    endtask

    task automatic test_single_req0();
        do_reset();
        @(negedge clk);
        req0_valid = 1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 2'b00; req0_neg = 0;
        #1;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_grant: got %b%b want 10", req0_ready, req1_ready); end n_assert++;
        @(negedge clk);
        if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_pulse: got %b want 0", req0_ready); end n_assert++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_exec: busy %b rsp_valid %b want 1 0", busy, rsp_valid); end n_assert++;
        req0_valid = 0;
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h08 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_rsp: got v%b %h id%b want v1 08 id0", rsp_valid, rsp_data, rsp_id); end n_assert++;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: v%b busy%b want 0 0", rsp_valid, busy); end n_assert++;
        if (done_cnt0 !== 16'd1 || done_cnt1 !== 16'd0) begin n_fail++; $display("FAIL single_cnt: got %0d/%0d want 1/0", done_cnt0, done_cnt1); end n_assert++;
    endtask

    task automatic test_req1();
        logic [7:0] d; logic rid; int lat;
        issue(1, 8'h03, 8'h05, 2'b01, 0, d, rid, lat);
        if (d !== 8'hFE || rid !== 1'b1) begin n_fail++; $display("FAIL req1_sub: got %h id%b want fe id1", d, rid); end n_assert++;
        if (lat != 2) begin n_fail++; $display("FAIL req1_latency: got %0d want 2", lat); end n_assert++;
        issue(1, 8'hF0, 8'h3C, 2'b10, 1, d, rid, lat);
        if (d !== 8'hCF || rid !== 1'b1) begin n_fail++; $display("FAIL req1_and_neg: got %h id%b want cf id1", d, rid); end n_assert++;
        if (done_cnt1 !== 16'd2) begin n_fail++; $display("FAIL req1_cnt: got %0d want 2", done_cnt1); end n_assert++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] dq[4]; logic iq[4]; int cq[4]; int k; int cyc;
        logic [7:0] exp_d;
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 2'b00; req0_neg = 0;
        req1_valid = 1; req1_a = 8'h0F; req1_b = 8'hF0; req1_op = 2'b11; req1_neg = 0;
        k = 0;
        for (cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin dq[k] = rsp_data; iq[k] = rsp_id; cq[k] = cyc; k++; end
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        rsp_ready = 0;
        if (k != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", k); end n_assert++;
        for (int i = 0; i < k; i++) begin
            exp_d = (i % 2 == 0) ? 8'h02 : 8'hFF;
            if (iq[i] !== 1'(i % 2) || dq[i] !== exp_d) begin n_fail++; $display("FAIL b2b_rsp%0d: got %h id%b want %h id%0d", i, dq[i], iq[i], exp_d, i % 2); end n_assert++;
            if (i > 0) begin
                if (cq[i] - cq[i-1] != 3) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 3", i, cq[i] - cq[i-1]); end n_assert++;
            end
        end
        if (done_cnt0 !== 16'd2 || done_cnt1 !== 16'd2) begin n_fail++; $display("FAIL b2b_cnt: got %0d/%0d want 2/2", done_cnt0, done_cnt1); end n_assert++;
    endtask

    task automatic test_backpressure();
        rsp_ready = 0;
        @(negedge clk);
        req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20; req0_op = 2'b00; req0_neg = 0;
        #1;
        if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b want 1", req0_ready); end n_assert++;
        @(negedge clk);
        req0_a = 8'hAA; req0_op = 2'b01;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h30 || rsp_id !== 1'b0 || req0_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: v%b %h id%b rdy%b want v1 30 id0 rdy0", i, rsp_valid, rsp_data, rsp_id, req0_ready);
            end
            n_assert++;
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
            @(negedge clk);
        end
        rsp_ready = 1; req0_valid = 0;
        @(negedge clk);
        rsp_ready = 0;
        if (rsp_valid !== 1'b0 || done_cnt0 !== 16'd3) begin n_fail++; $display("FAIL bp_release: v%b cnt%0d want v0 cnt3", rsp_valid, done_cnt0); end n_assert++;
    endtask

    task automatic test_reset_midop();
        do_reset();
        // reset during EXEC
        @(negedge clk);
        req1_valid = 1; req1_a = 8'h11; req1_b = 8'h22; req1_op = 2'b00; req1_neg = 0;
        @(negedge clk);
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rexec_state: busy%b v%b want 1 0", busy, rsp_valid); end n_assert++;
        rst_n = 0; req1_valid = 0;
        @(negedge clk);
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 1'b0 || done_cnt1 !== 16'd0) begin
            n_fail++; $display("FAIL rexec_cleared: busy%b v%b %h id%b cnt%0d want 0 0 00 0 0", busy, rsp_valid, rsp_data, rsp_id, done_cnt1);
        end
        n_assert++;
        rst_n = 1;
        // reset during RESP, after a grant to requester 0
        req0_valid = 1; req0_a = 8'h33; req0_b = 8'h44; req0_op = 2'b11; req0_neg = 0;
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h77) begin n_fail++; $display("FAIL rresp_state: v%b %h want v1 77", rsp_valid, rsp_data); end n_assert++;
        rst_n = 0; rsp_ready = 1;
        @(negedge clk);
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || done_cnt0 !== 16'd0 || done_cnt1 !== 16'd0) begin
            n_fail++; $display("FAIL rresp_cleared: busy%b v%b %h cnt%0d/%0d want 0 0 00 0/0", busy, rsp_valid, rsp_data, done_cnt0, done_cnt1);
        end
        n_assert++;
        rst_n = 1; rsp_ready = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rgrant_after_reset: got %b%b want 10", req0_ready, req1_ready); end n_assert++;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_wrap();
        logic [7:0] d; logic rid; int lat;
        do_reset();
        issue(0, 8'hFF, 8'h01, 2'b00, 0, d, rid, lat);
        if (d !== 8'h00) begin n_fail++; $display("FAIL wrap_add: got %h want 00", d); end n_assert++;
        issue(0, 8'hFF, 8'h01, 2'b00, 1, d, rid, lat);
        if (d !== 8'hFF) begin n_fail++; $display("FAIL wrap_add_neg: got %h want ff", d); end n_assert++;
        issue(0, 8'h80, 8'h80, 2'b00, 0, d, rid, lat);
        if (d !== 8'h00) begin n_fail++; $display("FAIL wrap_add80: got %h want 00", d); end n_assert++;
        if (w_done_cnt0 !== 2'd3) begin n_fail++; $display("FAIL wrap_cnt3: got %0d want 3", w_done_cnt0); end n_assert++;
        issue(0, 8'h0F, 8'h0F, 2'b10, 1, d, rid, lat);
        if (d !== 8'hF0) begin n_fail++; $display("FAIL wrap_and_neg: got %h want f0", d); end n_assert++;
        if (w_done_cnt0 !== 2'd0) begin n_fail++; $display("FAIL wrap_cnt_rollover: got %0d want 0", w_done_cnt0); end n_assert++;
        if (done_cnt0 !== 16'd4) begin n_fail++; $display("FAIL wrap_cnt_wide: got %0d want 4", done_cnt0); end n_assert++;
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_req1();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
